// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline stage built from a main register and a skid register.
// in_ready comes from registered state only. Define PIPE_SKID_STALL_CNT_EN to add stall_cnt.
module pipe_skid_stage #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PIPE_SKID_STALL_CNT_EN
  output logic [31:0]      stall_cnt,
`endif
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept, pop;

  assign out_valid = (state_q != StEmpty);
  assign in_ready  = (state_q != StFull);
  assign out_data  = main_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          main_d  = in_data;
        end
      end
      StOne: begin
        if (accept && pop) begin
          main_d = in_data;
        end else if (accept) begin
          // Main stays the older beat; the younger one parks in skid.
          state_d = StFull;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          state_d = StOne;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Squash everything held; a beat accepted on this edge is dropped.
    if (flush) begin
      state_d = StEmpty;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage, plus a randomized ordering scoreboard.
module tb_pipe_skid_stage;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_skid_stage #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef PIPE_SKID_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] model_q[$];
  logic [W-1:0] next_val;
  bit           m_accept, m_pop;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_data", out_data, 64'd0);
    reset = 1'b0;

    // Streaming at full rate: one cycle latency, no bubbles.
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 64'h1; step();
    check("s1_data", out_data, 64'h1);
    check("s1_valid", {63'd0, out_valid}, 64'd1);
    in_data = 64'h2; step();
    check("s2_data", out_data, 64'h2);
    check("s2_ready", {63'd0, in_ready}, 64'd1);
    in_data = 64'h3; step();
    check("s3_data", out_data, 64'h3);
    check("s3_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0; step();
    check("s_drain_valid", {63'd0, out_valid}, 64'd0);

    // Back-pressure: A, B fill the stage, C must wait.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 64'hA; step();
    check("bp_a_data", out_data, 64'hA);
    check("bp_one_ready", {63'd0, in_ready}, 64'd1);
    in_data = 64'hB; step();
    check("bp_full_ready", {63'd0, in_ready}, 64'd0);
    check("bp_full_data", out_data, 64'hA);
    in_data = 64'hC; step();
    check("bp_hold_data", out_data, 64'hA);
    check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1; #2;
    check("bp_ready_indep_hi", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b0; #2;
    check("bp_ready_indep_lo", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1; step();
    check("bp_b_data", out_data, 64'hB);
    check("bp_b_ready", {63'd0, in_ready}, 64'd1);
    step();
    check("bp_c_data", out_data, 64'hC);
    check("bp_c_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0; step();
    check("bp_empty_valid", {63'd0, out_valid}, 64'd0);

    // Flush while full; the beat offered on the flush edge is dropped.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 64'h11; step();
    in_data = 64'h22; step();
    check("fl_full_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b1; in_data = 64'h33; step();
    check("fl_valid", {63'd0, out_valid}, 64'd0);
    check("fl_ready", {63'd0, in_ready}, 64'd1);
    flush = 1'b0; in_valid = 1'b0; step();
    check("fl_stay_empty", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset between edges while full.
    in_valid = 1'b1;
    in_data = 64'h44; step();
    in_data = 64'h55; step();
    in_valid = 1'b0;
    check("ar_full_ready", {63'd0, in_ready}, 64'd0);
    #2 reset = 1'b1; #1;
    check("ar_valid", {63'd0, out_valid}, 64'd0);
    check("ar_ready", {63'd0, in_ready}, 64'd1);
    check("ar_data", out_data, 64'd0);
    #1 reset = 1'b0;

    // Random handshakes against a two-entry FIFO model.
    next_val = 64'h100;
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = in_valid ? next_val : 64'hDEAD_BEEF;
      check("rnd_valid", {63'd0, out_valid}, {63'd0, model_q.size() > 0});
      check("rnd_ready", {63'd0, in_ready}, {63'd0, model_q.size() < 2});
      m_pop    = (model_q.size() > 0) && out_ready;
      m_accept = (model_q.size() < 2) && in_valid;
      if (m_pop) check("rnd_data", out_data, model_q[0]);
      if (m_pop) void'(model_q.pop_front());
      if (m_accept) begin
        model_q.push_back(next_val);
        next_val++;
      end
      step();
    end

    // Stall accounting: 5 stalled cycles, flush with a pop, then reset.
    in_valid = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b1; #2 reset = 1'b0;
    in_valid = 1'b1; in_data = 64'h66; step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("st_hold_data", out_data, 64'h66);
`ifdef PIPE_SKID_STALL_CNT_EN
    check("st_cnt5", {32'd0, stall_cnt}, 64'd5);
`endif
    out_ready = 1'b1; flush = 1'b1; step();
    flush = 1'b0; out_ready = 1'b0;
    check("st_flush_valid", {63'd0, out_valid}, 64'd0);
`ifdef PIPE_SKID_STALL_CNT_EN
    check("st_cnt_after_flush", {32'd0, stall_cnt}, 64'd5);
    #2 reset = 1'b1; #1;
    check("st_cnt_reset", {32'd0, stall_cnt}, 64'd0);
    reset = 1'b0;
`endif
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
